// File: rtl/result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : result_streamer
//  Purpose  : Serialises NUM_WORDS result words of WORD_W bits onto an 8-bit
//             valid/ready byte stream. Frame = header {4'hA, mode}, payload
//             bytes (word 0 first, each word MSB byte first), then an optional
//             XOR checksum of header and payload.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             ena             - global enable, low freezes the block
//             start           - frame request, sampled in IDLE only
//             mode            - regime code, captured on start
//             words           - result words, captured on start
//             out_ready       - consumer accepts the presented byte
//             out_byte        - presented byte (0 when out_valid is low)
//             out_valid       - out_byte is valid
//             busy            - frame in progress (HDR/PAY/CHK)
//             done            - one-cycle pulse after the last byte
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module result_streamer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2,
  parameter int MODE_W    = 3,
  parameter int CHK_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          start,
  input  logic [MODE_W-1:0]             mode,
  input  logic [NUM_WORDS*WORD_W-1:0]   words,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int BPW       = WORD_W / 8;
  localparam int NUM_BYTES = NUM_WORDS * BPW;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]                  r_state;
  logic [2:0]                  w_next;
  logic [MODE_W-1:0]           r_mode;
  logic [NUM_WORDS*WORD_W-1:0] r_words;
  logic [CNT_W-1:0]            r_cnt;
  logic [7:0]                  r_acc;

  logic [7:0] w_hdr;
  logic [7:0] w_pay_byte;
  logic [7:0] w_cur;
  logic       w_accept;
  logic       w_last;
  logic       w_capture;

  assign w_hdr     = {4'hA, 4'(r_mode)};
  assign w_accept  = out_valid & out_ready;
  assign w_last    = (r_cnt == CNT_W'(NUM_BYTES - 1));
  assign w_capture = (r_state == S_IDLE) & ena & start;

  // Payload byte k lives in word k/BPW, byte (BPW-1 - k%BPW) of that word,
  // so each word goes out MSB byte first.
  always_comb begin
    w_pay_byte = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_pay_byte = r_words[(k / BPW) * WORD_W + (BPW - 1 - (k % BPW)) * 8 +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; accepts are impossible while ena is low, so every
  // transition out of HDR/PAY/CHK is frozen automatically.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ena && start) w_next = S_HDR;
      S_HDR:  if (w_accept) w_next = S_PAY;
      S_PAY:  if (w_accept && w_last) w_next = (CHK_EN != 0) ? S_CHK : S_DONE;
      S_CHK:  if (w_accept) w_next = S_DONE;
      S_DONE: if (ena) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_cur     = 8'h00;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_HDR: begin
        w_cur     = w_hdr;
        out_valid = ena;
        busy      = 1'b1;
      end
      S_PAY: begin
        w_cur     = w_pay_byte;
        out_valid = ena;
        busy      = 1'b1;
      end
      S_CHK: begin
        w_cur     = r_acc;
        out_valid = ena;
        busy      = 1'b1;
      end
      S_DONE: done = ena;
      default: ;
    endcase
    out_byte = out_valid ? w_cur : 8'h00;
  end

  // Capture, byte counter and checksum accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= '0;
      r_words <= '0;
      r_cnt   <= '0;
      r_acc   <= 8'h00;
    end else begin
      if (w_capture) begin
        r_mode  <= mode;
        r_words <= words;
        r_cnt   <= '0;
      end
      if (w_accept && r_state == S_HDR) begin
        r_acc <= w_hdr;
        r_cnt <= '0;
      end
      if (w_accept && r_state == S_PAY) begin
        r_acc <= r_acc ^ w_pay_byte;
        if (!w_last) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_streamer
//  Purpose  : Directed self-checking bench for result_streamer. Instance A
//             uses default parameters, instance B uses WORD_W=16,
//             NUM_WORDS=3, CHK_EN=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_streamer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        out_ready;

  logic        start_a;
  logic [2:0]  mode_a;
  logic [63:0] words_a;
  logic [7:0]  byte_a;
  logic        valid_a, busy_a, done_a;

  logic        start_b;
  logic [2:0]  mode_b;
  logic [47:0] words_b;
  logic [7:0]  byte_b;
  logic        valid_b, busy_b, done_b;

  result_streamer u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_a), .mode(mode_a),
    .words(words_a), .out_ready(out_ready), .out_byte(byte_a),
    .out_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  result_streamer #(.WORD_W(16), .NUM_WORDS(3), .MODE_W(3), .CHK_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_b), .mode(mode_b),
    .words(words_b), .out_ready(out_ready), .out_byte(byte_b),
    .out_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Currently observed instance
  logic       dsel;
  logic [7:0] c_byte;
  logic       c_valid, c_busy, c_done;
  assign c_byte  = dsel ? byte_b  : byte_a;
  assign c_valid = dsel ? valid_b : valid_a;
  assign c_busy  = dsel ? busy_b  : busy_a;
  assign c_done  = dsel ? done_b  : done_a;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got[$];
  int busy_cyc, done_cnt, unstable;

  logic [7:0] exp_a[$] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78,
                           8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hA5};
  logic [7:0] exp_b[$] = '{8'hA1, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Pulse start on the selected instance; returns one cycle later at posedge+1.
  task automatic start_frame(input bit sel);
    dsel = sel;
    if (sel) begin
      words_b = 48'h0003_0002_0001; mode_b = 3'd1; start_b = 1'b1;
    end else begin
      words_a = 64'h9ABCDEF0_12345678; mode_a = 3'b101; start_a = 1'b1;
    end
    #1;
    check_eq("idle_busy", {31'd0, c_busy}, 32'd0);
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Collect bytes until done plus a few trailing cycles.
  // rdy_mode 0: ready always high; 1: ready pattern 1,0,0,1,0,0,...
  task automatic drain(input int rdy_mode, input int gap_at, input bit mid_start);
    logic [7:0] held;
    bit pend, gapped, done_seen;
    int post;
    got.delete();
    busy_cyc = 0; done_cnt = 0; unstable = 0;
    pend = 0; gapped = 0; done_seen = 0; post = 0; held = 8'h00;
    for (int cyc = 0; cyc < 80; cyc++) begin
      out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (mid_start && cyc == 4) begin
        start_a = 1'b1; mode_a = 3'd0; words_a = 64'd0;
      end
      if (mid_start && cyc == 5) start_a = 1'b0;
      if (gap_at >= 0 && !gapped && got.size() == gap_at) begin
        gapped = 1;
        ena = 1'b0;
        for (int g = 0; g < 3; g++) begin
          #1;
          check_eq("gap_valid", {31'd0, c_valid}, 32'd0);
          @(posedge clk); #1;
        end
        ena = 1'b1;
        #1;
        check_eq("gap_represent", {24'd0, c_byte}, 32'h56);
      end
      #1;
      if (c_valid) begin
        if (pend && c_byte !== held) unstable++;
        if (out_ready) begin
          got.push_back(c_byte);
          pend = 0;
        end else begin
          pend = 1;
          held = c_byte;
        end
      end
      if (c_busy) busy_cyc++;
      if (c_done) begin
        done_cnt++;
        done_seen = 1;
      end
      if (done_seen) post++;
      @(posedge clk); #1;
      if (post >= 4) break;
    end
    if (!done_seen) check_eq("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_seq(input string tag, input logic [7:0] exp_q[$]);
    check_eq({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i),
               (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; out_ready = 1'b0; dsel = 1'b0;
    start_a = 1'b0; mode_a = 3'd0; words_a = 64'd0;
    start_b = 1'b0; mode_b = 3'd0; words_b = 48'd0;

    // Reset state
    #12;
    check_eq("rst_valid_a", {31'd0, valid_a}, 32'd0);
    check_eq("rst_byte_a",  {24'd0, byte_a},  32'd0);
    check_eq("rst_busy_a",  {31'd0, busy_a},  32'd0);
    check_eq("rst_done_a",  {31'd0, done_a},  32'd0);
    check_eq("rst_valid_b", {31'd0, valid_b}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame
    out_ready = 1'b1;
    start_frame(0);
    check_eq("hdr_latency_valid", {31'd0, valid_a}, 32'd1);
    check_eq("hdr_latency_byte",  {24'd0, byte_a},  32'hA5);
    drain(0, -1, 0);
    compare_seq("basic", exp_a);
    check_eq("basic_done_cnt", done_cnt, 32'd1);
    check_eq("basic_busy_cyc", busy_cyc, 32'd10);

    // Backpressure
    start_frame(0);
    drain(1, -1, 0);
    compare_seq("bp", exp_a);
    check_eq("bp_stable", unstable, 32'd0);
    check_eq("bp_done_cnt", done_cnt, 32'd1);

    // ena gap while 0x56 pending
    start_frame(0);
    drain(0, 3, 0);
    compare_seq("gap", exp_a);
    check_eq("gap_done_cnt", done_cnt, 32'd1);

    // start while busy with changed inputs
    start_frame(0);
    drain(0, -1, 1);
    compare_seq("midstart", exp_a);
    check_eq("midstart_done_cnt", done_cnt, 32'd1);
    check_eq("midstart_idle_busy",  {31'd0, busy_a},  32'd0);
    check_eq("midstart_idle_valid", {31'd0, valid_a}, 32'd0);

    // Parametrised instance
    start_frame(1);
    drain(0, -1, 0);
    compare_seq("param", exp_b);
    check_eq("param_done_cnt", done_cnt, 32'd1);
    check_eq("param_busy_cyc", busy_cyc, 32'd7);

    // Reset mid-frame
    start_frame(0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, valid_a}, 32'd0);
    check_eq("midrst_byte",  {24'd0, byte_a},  32'd0);
    check_eq("midrst_busy",  {31'd0, busy_a},  32'd0);
    check_eq("midrst_done",  {31'd0, done_a},  32'd0);
    #2;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done_a) done_cnt++;
    end
    check_eq("midrst_no_done", done_cnt, 32'd0);
    start_frame(0);
    drain(0, -1, 0);
    compare_seq("postrst", exp_a);
    check_eq("postrst_done_cnt", done_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Parametrised successor to the fixed two-word output loader. It serialises NUM_WORDS result words of WORD_W bits onto the 8-bit output pins.
- Each frame is a header byte carrying the regime/mode, then the payload bytes, then an optional XOR checksum byte.
- Every byte uses a valid/ready handshake, so a downstream pin sequencer or test harness can apply backpressure.
- Sits between the eigen/kappa compute core and uo_out in the watchdog top level.

Parameters:
- WORD_W, 32, width of each result word; must be a multiple of 8 and at least 8.
- NUM_WORDS, 2, number of words per frame; at least 1.
- MODE_W, 3, width of the mode field; 1..4.
- CHK_EN, 1, 1 appends the XOR checksum byte; 0 omits it.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; low freezes the block.
- start  in  1  request to send a frame; sampled in IDLE only.
- mode  in  MODE_W  regime code, captured on start.
- words  in  NUM_WORDS*WORD_W  word i occupies bits [(i+1)*WORD_W-1 : i*WORD_W]; captured on start.
- out_ready  in  1  consumer accepts the current byte.
- out_byte  out  8  byte being presented; 0 when out_valid is low.
- out_valid  out  1  out_byte is valid.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values (asynchronous): state=IDLE, out_byte=0, out_valid=0, busy=0, done=0, capture registers=0, byte counter=0, checksum accumulator=0.
- States: IDLE, HDR, PAY, CHK, DONE.
- IDLE:
  - When start=1 and ena=1, capture mode and words and go to HDR.
  - busy and out_valid assert in the following cycle, so the header is presented one cycle after start.
- HDR:
  - out_byte = {4'hA, mode zero-extended to 4 bits}.
  - On accept (out_valid & out_ready), go to PAY and set the checksum accumulator to the header value.
- PAY:
  - Sends NUM_WORDS*WORD_W/8 bytes: word 0 first, each word MSB byte first.
  - A byte counter indexes the captured vector and advances only on accept.
  - Each accepted byte is XORed into the accumulator.
  - After the last payload byte is accepted: go to CHK if CHK_EN=1, otherwise to DONE.
- CHK: out_byte = accumulator, i.e. the XOR of the header and all payload bytes. On accept, go to DONE.
- DONE:
  - out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
  - A start in the DONE cycle is ignored.
- Frame length = 1 + NUM_WORDS*WORD_W/8 + CHK_EN bytes.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_byte holds stable and the state holds.
  - With out_ready held high, one byte is transferred per cycle and there are no bubbles between bytes.
- ena=0:
  - The state, counter and accumulator freeze.
  - out_valid is forced to 0 and no accept can occur.
  - When ena returns, the same pending byte is re-presented.
  - done is held off while ena=0 and pulses once ena returns.
- start while busy (HDR/PAY/CHK/DONE): ignored. The captured data is not overwritten.
- Input changes: changes on mode and words after capture have no effect on the frame in flight.
- Reset mid-frame: immediately aborts to IDLE with all outputs 0. No done pulse is issued.
- Reset mid-frame at the consumer side: the consumer must treat a header byte (upper nibble A) as a frame restart.

Test Plan:
- Basic frame, defaults, out_ready=1:
  - Stimulus: words={0x9ABCDEF0, 0x12345678} (word0=0x12345678), mode=3'b101, 1-cycle start.
  - Response: header appears 1 cycle later, then bytes A5,12,34,56,78,9A,BC,DE,F0,A5 on consecutive cycles.
  - done pulses once, in the cycle after the last byte; busy is high for 10 cycles.
- Backpressure:
  - Stimulus: same frame, out_ready toggled 1,0,0,1,...
  - Response: no byte is dropped or repeated; out_byte is stable while ready=0; the byte sequence is identical to the basic frame.
- ena gap:
  - Stimulus: deassert ena for 3 cycles while byte 0x56 is pending.
  - Response: out_valid=0 during the gap; 0x56 is re-presented when ena returns and the frame completes normally.
- Start while busy and input changes:
  - Stimulus: pulse start with words=0 and mode=0 mid-frame.
  - Response: the frame in flight is unchanged, no second frame starts, and exactly one done pulse occurs.
- Parametrised configuration:
  - Stimulus: WORD_W=16, NUM_WORDS=3, CHK_EN=0, words={0x0003, 0x0002, 0x0001}, mode=1.
  - Response: A1,00,01,00,02,00,03, then done; 7 bytes total.
- Reset mid-frame:
  - Stimulus: assert rst_n low during the PAY state.
  - Response: out_valid, out_byte, busy and done are all 0 asynchronously; no done pulse.
  - A new start after reset produces a clean frame beginning with the header byte.
